// File: rtl/psu_pson_ctrl.sv
// PSU PS_ON initiator: drives PS_ON from PCH S3 exit, qualifies PSU PWROK and
// latches PWROK timeout / loss / stuck-high faults. All outputs are decoded from nxtState.
module psu_pson_ctrl #(
    parameter int unsigned      CNT_W      = 24,
    parameter logic [CNT_W-1:0] T_PWROK_TO = 24'd1_000_000,
    parameter logic [15:0]      T_DBNC     = 16'd1_000,
    parameter logic [CNT_W-1:0] T_MIN_OFF  = 24'd500_000
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       ienable,
    input  logic       iFM_SLP3_N,
    input  logic       iPWRGD_PS_PWROK_PLD_R,
    input  logic       iForceOff,
    input  logic       iFaultClr,
    output logic       oFM_PS_EN,
    output logic       oPsuPwrgd,
    output logic       oPsuFault,
    output logic [1:0] oFaultCode
);

    // state       | meaning
    // ST_IDLE     | PS_ON low, waiting for S0 request
    // ST_ON_WAIT  | PS_ON high, waiting for PWROK
    // ST_DBNC     | PWROK seen, qualifying it
    // ST_ON       | PSU good
    // ST_OFF_WAIT | PS_ON low, enforcing minimum off time
    // ST_FAULT    | fault latched until cleared
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ON_WAIT  = 3'd1;
    localparam logic [2:0] ST_DBNC     = 3'd2;
    localparam logic [2:0] ST_ON       = 3'd3;
    localparam logic [2:0] ST_OFF_WAIT = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    localparam logic [CNT_W-1:0] TMO_LAST = T_PWROK_TO - 1'b1;
    localparam logic [CNT_W-1:0] OFF_LAST = T_MIN_OFF - 1'b1;
    localparam logic [15:0]      DBC_LAST = T_DBNC - 1'b1;

    logic [2:0]       state, nxtState;
    logic [CNT_W-1:0] tmoCnt, tmoNxt;
    logic [15:0]      dbcCnt, dbcNxt;
    logic [1:0]       codeNxt;
    logic             pwrok, shdn, tmoLast;

    assign pwrok   = iPWRGD_PS_PWROK_PLD_R;
    assign shdn    = !iFM_SLP3_N || iForceOff || !ienable;
    assign tmoLast = (tmoCnt == TMO_LAST);

    always_comb begin
        nxtState = state;
        codeNxt  = oFaultCode;
        case (state)
            ST_IDLE: begin
                if (ienable && iFM_SLP3_N && !iForceOff) nxtState = ST_ON_WAIT;
            end
            ST_ON_WAIT: begin
                if (shdn) nxtState = ST_OFF_WAIT;
                else if (pwrok) nxtState = ST_DBNC;
                else if (tmoLast) begin
                    nxtState = ST_FAULT;
                    codeNxt  = 2'b01;
                end
            end
            ST_DBNC: begin
                if (shdn) nxtState = ST_OFF_WAIT;
                else if (!pwrok) nxtState = ST_ON_WAIT;
                else if (dbcCnt == DBC_LAST) nxtState = ST_ON;
                else if (tmoLast) begin
                    nxtState = ST_FAULT;
                    codeNxt  = 2'b01;
                end
            end
            ST_ON: begin
                // orderly shutdown wins over a coincident PWROK drop
                if (shdn) nxtState = ST_OFF_WAIT;
                else if (!pwrok) begin
                    nxtState = ST_FAULT;
                    codeNxt  = 2'b10;
                end
            end
            ST_OFF_WAIT: begin
                if ((tmoCnt >= OFF_LAST) && !pwrok) nxtState = ST_IDLE;
                else if (tmoLast && pwrok) begin
                    nxtState = ST_FAULT;
                    codeNxt  = 2'b11;
                end
            end
            ST_FAULT: begin
                if (iFaultClr && !iFM_SLP3_N && !pwrok) begin
                    nxtState = ST_IDLE;
                    codeNxt  = 2'b00;
                end
            end
            default: begin
                nxtState = ST_IDLE;
                codeNxt  = 2'b00;
            end
        endcase
    end

    // tmo is not cleared on DBNC -> ON_WAIT, so PWROK chatter cannot extend the timeout
    always_comb begin
        tmoNxt = tmoCnt;
        if ((state == ST_IDLE) || ((nxtState == ST_OFF_WAIT) && (state != ST_OFF_WAIT)))
            tmoNxt = '0;
        else if (tmoCnt != T_PWROK_TO)
            tmoNxt = tmoCnt + 1'b1;

        dbcNxt = dbcCnt;
        if (state != ST_DBNC)
            dbcNxt = '0;
        else if (pwrok && (dbcCnt != T_DBNC))
            dbcNxt = dbcCnt + 1'b1;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state      <= ST_IDLE;
            tmoCnt     <= '0;
            dbcCnt     <= '0;
            oFM_PS_EN  <= 1'b0;
            oPsuPwrgd  <= 1'b0;
            oPsuFault  <= 1'b0;
            oFaultCode <= 2'b00;
        end else begin
            state      <= nxtState;
            tmoCnt     <= tmoNxt;
            dbcCnt     <= dbcNxt;
            oFM_PS_EN  <= (nxtState == ST_ON_WAIT) || (nxtState == ST_DBNC) || (nxtState == ST_ON);
            oPsuPwrgd  <= (nxtState == ST_ON);
            oPsuFault  <= (nxtState == ST_FAULT);
            oFaultCode <= codeNxt;
        end
    end

endmodule

// File: tb/tb_psu_pson_ctrl.sv
// Scoreboard bench for psu_pson_ctrl: a timestamp-based reference model predicts
// each cycle's outputs into a queue; a monitor pops and compares after every edge.
module tb_psu_pson_ctrl;

    localparam int TO_I = 100;
    localparam int DB_I = 4;
    localparam int MO_I = 10;

    logic       iClk = 1'b0;
    logic       iRst_n, ienable, iFM_SLP3_N, iPWRGD_PS_PWROK_PLD_R, iForceOff, iFaultClr;
    logic       oFM_PS_EN, oPsuPwrgd, oPsuFault;
    logic [1:0] oFaultCode;

    always #5 iClk = ~iClk;

    psu_pson_ctrl #(
        .CNT_W      (24),
        .T_PWROK_TO (24'd100),
        .T_DBNC     (16'd4),
        .T_MIN_OFF  (24'd10)
    ) dut (
        .iClk                  (iClk),
        .iRst_n                (iRst_n),
        .ienable               (ienable),
        .iFM_SLP3_N            (iFM_SLP3_N),
        .iPWRGD_PS_PWROK_PLD_R (iPWRGD_PS_PWROK_PLD_R),
        .iForceOff             (iForceOff),
        .iFaultClr             (iFaultClr),
        .oFM_PS_EN             (oFM_PS_EN),
        .oPsuPwrgd             (oPsuPwrgd),
        .oPsuFault             (oPsuFault),
        .oFaultCode            (oFaultCode)
    );

    typedef struct packed {
        logic       psEn;
        logic       pwrgd;
        logic       fault;
        logic [1:0] code;
    } exp_t;

    typedef enum int {M_IDLE, M_WAIT, M_DBNC, M_ON, M_OFF, M_FAULT} mode_t;

    exp_t  expQ[$];
    int    cycQ[$];
    int    checks = 0;
    int    errors = 0;

    mode_t mode   = M_IDLE;
    int    mCode  = 0;
    int    cyc    = 0;
    int    tStart = 0;
    int    dStart = 0;
    logic  rst_r = 1'b0, en_r = 1'b1, slp_r = 1'b0, pw_r = 1'b0, frc_r = 1'b0, clr_r = 1'b0;

    // Timers are elapsed cycles since the phase timestamp, saturating at the timeout.
    task automatic modelStep();
        int   tmo;
        logic shdn;
        exp_t e;
        shdn = !slp_r || frc_r || !en_r;
        tmo  = cyc - tStart;
        if (tmo > TO_I) tmo = TO_I;
        if (!rst_r) begin
            mode  = M_IDLE;
            mCode = 0;
        end else begin
            case (mode)
                M_IDLE: if (en_r && slp_r && !frc_r) begin mode = M_WAIT; tStart = cyc + 1; end
                M_WAIT: begin
                    if (shdn) begin mode = M_OFF; tStart = cyc + 1; end
                    else if (pw_r) begin mode = M_DBNC; dStart = cyc + 1; end
                    else if (tmo == TO_I - 1) begin mode = M_FAULT; mCode = 1; end
                end
                M_DBNC: begin
                    if (shdn) begin mode = M_OFF; tStart = cyc + 1; end
                    else if (!pw_r) mode = M_WAIT;
                    else if (cyc - dStart == DB_I - 1) mode = M_ON;
                    else if (tmo == TO_I - 1) begin mode = M_FAULT; mCode = 1; end
                end
                M_ON: begin
                    if (shdn) begin mode = M_OFF; tStart = cyc + 1; end
                    else if (!pw_r) begin mode = M_FAULT; mCode = 2; end
                end
                M_OFF: begin
                    if (tmo >= MO_I - 1 && !pw_r) mode = M_IDLE;
                    else if (tmo == TO_I - 1 && pw_r) begin mode = M_FAULT; mCode = 3; end
                end
                M_FAULT: if (clr_r && !slp_r && !pw_r) begin mode = M_IDLE; mCode = 0; end
                default: mode = M_IDLE;
            endcase
        end
        e.psEn  = (mode == M_WAIT) || (mode == M_DBNC) || (mode == M_ON);
        e.pwrgd = (mode == M_ON);
        e.fault = (mode == M_FAULT);
        e.code  = 2'(mCode);
        expQ.push_back(e);
        cycQ.push_back(cyc);
        cyc++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iClk);
            iRst_n                = rst_r;
            ienable               = en_r;
            iFM_SLP3_N            = slp_r;
            iPWRGD_PS_PWROK_PLD_R = pw_r;
            iForceOff             = frc_r;
            iFaultClr             = clr_r;
            modelStep();
            clr_r = 1'b0;
        end
    endtask

    task automatic chk(input string name, input int c, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, c, got, want);
        end
    endtask

    initial begin
        exp_t e;
        int   c;
        forever begin
            @(posedge iClk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                c = cycQ.pop_front();
                chk("ps_en", c, {1'b0, oFM_PS_EN}, {1'b0, e.psEn});
                chk("pwrgd", c, {1'b0, oPsuPwrgd}, {1'b0, e.pwrgd});
                chk("fault", c, {1'b0, oPsuFault}, {1'b0, e.fault});
                chk("code",  c, oFaultCode, e.code);
            end
        end
    end

    task automatic goOn();
        en_r = 1'b1; frc_r = 1'b0; slp_r = 1'b1; pw_r = 1'b0;
        tick(4);
        pw_r = 1'b1;
        tick(8);
    endtask

    initial begin
        int pat[7] = '{1, 1, 0, 1, 1, 1, 1};
        iRst_n = 1'b0; ienable = 1'b1; iFM_SLP3_N = 1'b0;
        iPWRGD_PS_PWROK_PLD_R = 1'b0; iForceOff = 1'b0; iFaultClr = 1'b0;

        tick(3); rst_r = 1'b1; tick(2);

        // normal on: SLP3_N at 0, PWROK at 20
        slp_r = 1'b1; tick(20); pw_r = 1'b1; tick(30);

        // loss while on, ignored clear, real clear
        pw_r = 1'b0; tick(5);
        clr_r = 1'b1; tick(2);
        slp_r = 1'b0; tick(2); clr_r = 1'b1; tick(3);

        // SLP3_N and PWROK fall together in ON: orderly off
        goOn(); slp_r = 1'b0; pw_r = 1'b0; tick(15);

        // PWROK timeout
        slp_r = 1'b1; tick(105); clr_r = 1'b1; tick(2);
        slp_r = 1'b0; clr_r = 1'b1; tick(3);

        // bounce then stable high
        slp_r = 1'b1; tick(5);
        foreach (pat[i]) begin pw_r = pat[i][0]; tick(1); end
        tick(10);
        slp_r = 1'b0; tick(3); pw_r = 1'b0; tick(15);

        // chatter must not extend the timeout
        slp_r = 1'b1;
        for (int i = 0; i < 110; i++) begin pw_r = (i % 3 != 2); tick(1); end
        pw_r = 1'b0; slp_r = 1'b0; tick(2); clr_r = 1'b1; tick(3);

        // off timing, then SLP3_N re-raised during OFF_WAIT
        goOn(); slp_r = 1'b0; tick(3); pw_r = 1'b0; tick(15);
        goOn(); slp_r = 1'b0; tick(2); slp_r = 1'b1; tick(1); pw_r = 1'b0; tick(15);

        // PWROK stuck high after off
        goOn(); slp_r = 1'b0; tick(105); pw_r = 1'b0; clr_r = 1'b1; tick(3);

        // reset in ON, reset in FAULT, force-off in ON
        goOn(); rst_r = 1'b0; tick(1); rst_r = 1'b1; tick(3);
        goOn(); pw_r = 1'b0; tick(3); rst_r = 1'b0; tick(1); rst_r = 1'b1; slp_r = 1'b0; tick(3);
        goOn(); frc_r = 1'b1; tick(15); frc_r = 1'b0; pw_r = 1'b0; slp_r = 1'b0; tick(12);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0)  pw_r  = ~pw_r;
            if ($urandom_range(149) == 0) slp_r = ~slp_r;
            if ($urandom_range(299) == 0) en_r  = ~en_r;
            if ($urandom_range(399) == 0) frc_r = ~frc_r;
            clr_r = ($urandom_range(19) == 0);
            rst_r = ($urandom_range(999) != 0);
            tick(1);
        end

        @(posedge iClk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psu_pson_ctrl.md
Name: psu_pson_ctrl

Overview:
- Initiator side of the PSU power-good handshake: drives PS_ON (oFM_PS_EN) to the main PSU from PCH S3 exit and produces a debounced, qualified PSU power-good for downstream consumers such as the S3/P12V switch logic.
- Detects three faults: PWROK never arriving, PWROK lost while on, and PWROK stuck high after shutdown.
- Enforces a minimum off time before the PSU may be re-enabled.
- Sits between the PCH sleep signals, the PSU connector and the power-sequencing master.

Parameters:
- T_PWROK_TO, 24'd1_000_000: cycles allowed from PS_ON assert to qualified PWROK; also the limit for PWROK falling after PS_ON deassert.
- T_DBNC, 16'd1_000: consecutive cycles PWROK must stay high to qualify.
- T_MIN_OFF, 24'd500_000: minimum cycles PS_ON stays low before IDLE is re-entered.
- CNT_W, 24: width of the timeout/off counter; the debounce counter is 16 bits.

Ports:
- iClk  in  1  system clock
- iRst_n  in  1  reset, synchronous, active-low
- ienable  in  1  master enable; 0 in IDLE holds IDLE, 0 elsewhere acts as a shutdown request
- iFM_SLP3_N  in  1  PCH sleep-3; 1 = S0 requested
- iPWRGD_PS_PWROK_PLD_R  in  1  raw PSU PWROK, already synchronized
- iForceOff  in  1  level shutdown request (thermal/BMC)
- iFaultClr  in  1  single-cycle fault clear
- oFM_PS_EN  out  1  PS_ON to PSU, active-high
- oPsuPwrgd  out  1  qualified PSU power-good
- oPsuFault  out  1  fault latched
- oFaultCode  out  2  00 none, 01 PWROK timeout, 10 PWROK lost while on, 11 PWROK stuck high after off

Behaviour:
- Reset:
  - Reset is synchronous, applied on the clock edge with iRst_n=0. It overrides every state, including mid-operation and FAULT.
  - Reset values: state IDLE; oFM_PS_EN=0, oPsuPwrgd=0, oPsuFault=0, oFaultCode=00; both counters 0.
- Output timing: all outputs are registered, decoded from nxtState, so each output changes on the same edge the state changes (1-cycle latency from the sampled input).
- Shutdown request (shdn) = !iFM_SLP3_N | iForceOff | !ienable.
- IDLE: PS_EN=0.
  - ienable & iFM_SLP3_N & !iForceOff -> ON_WAIT; clear tmo counter.
- ON_WAIT: PS_EN=1. tmo increments each cycle, saturating at T_PWROK_TO. Priority order:
  - shdn -> OFF_WAIT.
  - else PWROK=1 -> DBNC; clear dbc.
  - else tmo==T_PWROK_TO-1 -> FAULT, code 01.
- DBNC: PS_EN=1. tmo keeps counting; dbc increments while PWROK=1. Priority order:
  - shdn -> OFF_WAIT.
  - else PWROK=0 -> ON_WAIT (tmo not cleared, so bouncing cannot extend the timeout).
  - else dbc==T_DBNC-1 -> ON.
  - else tmo==T_PWROK_TO-1 -> FAULT, code 01.
- ON: PS_EN=1, oPsuPwrgd=1.
  - shdn -> OFF_WAIT. This wins over a simultaneous PWROK drop: an orderly shutdown is not a fault.
  - else PWROK=0 -> FAULT, code 10; oPsuPwrgd falls on the same edge.
- OFF_WAIT: PS_EN=0, oPsuPwrgd=0; tmo cleared on entry and counts up, saturating.
  - tmo>=T_MIN_OFF-1 & PWROK=0 -> IDLE.
  - tmo==T_PWROK_TO-1 & PWROK=1 -> FAULT, code 11.
  - shdn deasserting here does not shorten the off time.
- FAULT: PS_EN=0, pwrgd=0, oPsuFault=1; code is held.
  - iFaultClr & !iFM_SLP3_N & !PWROK -> IDLE with code cleared to 00.
  - iFaultClr under any other condition is ignored.
- Invalid state encoding -> IDLE with all outputs 0.
- Counters never wrap; compare values are fixed by parameters. T_DBNC and T_MIN_OFF must each be below T_PWROK_TO.

Test Plan (T_PWROK_TO=100, T_DBNC=4, T_MIN_OFF=10):
- Normal on: ienable=1, SLP3_N rises at cycle 0, PWROK rises at cycle 20 and stays high -> PS_EN=1 from cycle 1; oPsuPwrgd=1 at cycle 25; no fault.
- Timeout: SLP3_N=1, PWROK held 0 -> FAULT entered 100 cycles after ON_WAIT entry; PS_EN=0, code=01. iFaultClr with SLP3_N=1 is ignored; iFaultClr with SLP3_N=0 -> IDLE, code=00.
- Bounce: in DBNC, PWROK toggles 1,1,0,1,1,1,1 -> returns to ON_WAIT on the 0; pwrgd asserts after 4 stable highs; tmo is not reset, verified by PWROK chatter forcing code 01 at cycle 100.
- Loss while on: in ON, PWROK drops with SLP3_N=1 -> next edge PS_EN=0, pwrgd=0, fault=1, code=10. Repeat with SLP3_N and PWROK falling on the same cycle -> OFF_WAIT, no fault.
- Off timing: SLP3_N falls in ON, PWROK falls 3 cycles later -> IDLE exactly 10 cycles after OFF_WAIT entry. If PWROK stays high -> code 11 after 100 cycles. Re-raising SLP3_N at cycle 2 of OFF_WAIT does not re-assert PS_EN before IDLE.
- Reset mid-operation: iRst_n=0 for 1 cycle while in ON and while in FAULT -> all outputs 0, state IDLE on the next edge; iForceOff=1 in ON -> OFF_WAIT.
